passcode_entry_collector: RTL and testbench



---
 rtl/passcode_pkg.sv | 14 +
 rtl/passcode_entry_collector_timeout.sv | 28 ++
 rtl/passcode_entry_collector.sv | 151 +++++++++++++++
 tb/tb_passcode_entry_collector.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/passcode_pkg.sv
// Shared types and default sizing for the passcode entry collector.
package passcode_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned DATA_W  = DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        LOAD
    } state_t;

endpackage

// File: rtl/passcode_entry_collector_timeout.sv
// Inter-digit idle timer for a partial passcode entry; expired is high on the
// last idle cycle unless a restart arrives in the same cycle.
module entry_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign expired = run && !restart && (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run || restart || expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/passcode_entry_collector.sv
// Assembles keypad digits MSB-first into a passcode word with a one-cycle load
// strobe. Optional inter-digit timeout enabled by defining ENTRY_TIMEOUT_EN.
module passcode_entry_collector #(
    parameter int unsigned DIGITS         = passcode_pkg::DIGITS,
    parameter int unsigned DIGIT_W        = passcode_pkg::DIGIT_W,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIGIT_W-1:0]          digit_in,
    input  logic                        digit_valid,
    input  logic                        clear,
    output logic [DIGITS*DIGIT_W-1:0]   data_out,
    output logic                        data_load,
    output logic [2:0]                  digit_count,
    output logic                        timeout
);

    localparam int unsigned DATA_W = DIGITS * DIGIT_W;

    import passcode_pkg::*;

    localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);

    if (DIGITS < 2 || DIGITS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("passcode_entry_collector: unsupported DIGITS or TIMEOUT_CYCLES");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                r_load;
    logic                w_load_nxt;
    logic [2:0]          r_count;
    logic [2:0]          w_count_nxt;
    logic [DATA_W-1:0]   w_shifted;

    assign w_shifted = {r_shift[DATA_W-DIGIT_W-1:0], digit_in};

`ifdef ENTRY_TIMEOUT_EN
    logic r_timeout;
    logic w_timeout_nxt;
    logic w_expired;
    logic w_run;
    logic w_restart;

    assign w_run     = (r_state == COLLECT);
    // clear also restarts so a clear in the expiry cycle never raises timeout
    assign w_restart = w_run && (digit_valid || clear);

    entry_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (w_run),
        .restart (w_restart),
        .expired (w_expired)
    );

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_data  <= '0;
            r_load  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_load  <= w_load_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_load_nxt  = 1'b0;
        w_count_nxt = r_count;
`ifdef ENTRY_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (digit_valid) begin
                    w_shift_nxt = w_shifted;
                    w_count_nxt = 3'd1;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (clear) begin
                    w_shift_nxt = '0;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (digit_valid) begin
                    if (r_count == LAST_DIGIT) begin
                        w_data_nxt  = w_shifted;
                        w_load_nxt  = 1'b1;
                        w_shift_nxt = '0;
                        w_count_nxt = '0;
                        w_state_nxt = LOAD;
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_count_nxt = r_count + 3'd1;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (w_expired) begin
                    w_shift_nxt   = '0;
                    w_count_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
`endif
            end
            LOAD: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign data_out    = r_data;
    assign data_load   = r_load;
    assign digit_count = r_count;

endmodule

// File: tb/tb_passcode_entry_collector.sv
// Directed bench for passcode_entry_collector; covers the timeout path when
// built with ENTRY_TIMEOUT_EN.
module tb_passcode_entry_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        clear;
    logic [15:0] data_out;
    logic        data_load;
    logic [2:0]  digit_count;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    passcode_entry_collector #(
        .DIGITS         (4),
        .DIGIT_W        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .clear       (clear),
        .data_out    (data_out),
        .data_load   (data_load),
        .digit_count (digit_count),
        .timeout     (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] e_data, input logic e_load,
                              input logic [2:0] e_count, input logic e_to);
        chk({tag, ".data_out"},    32'(data_out),    32'(e_data));
        chk({tag, ".data_load"},   32'(data_load),   32'(e_load));
        chk({tag, ".digit_count"}, 32'(digit_count), 32'(e_count));
        chk({tag, ".timeout"},     32'(timeout),     32'(e_to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        digit_in    = '0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        tick();
        tick();
        expect_out("reset", 16'h0000, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("idle", 16'h0000, 1'b0, 3'd0, 1'b0);

        // 1,4,7,6 -> 1476
        press(4'h1); expect_out("e1.d1", 16'h0000, 1'b0, 3'd1, 1'b0);
        press(4'h4); expect_out("e1.d2", 16'h0000, 1'b0, 3'd2, 1'b0);
        press(4'h7); expect_out("e1.d3", 16'h0000, 1'b0, 3'd3, 1'b0);
        press(4'h6); expect_out("e1.load", 16'h1476, 1'b1, 3'd0, 1'b0);
        tick();      expect_out("e1.after", 16'h1476, 1'b0, 3'd0, 1'b0);

        // 2,3, clear, 4,7,8,9 -> 4789
        press(4'h2); expect_out("e2.d1", 16'h1476, 1'b0, 3'd1, 1'b0);
        press(4'h3); expect_out("e2.d2", 16'h1476, 1'b0, 3'd2, 1'b0);
        pulse_clear(); expect_out("e2.clear", 16'h1476, 1'b0, 3'd0, 1'b0);
        press(4'h4); expect_out("e2.d4", 16'h1476, 1'b0, 3'd1, 1'b0);
        press(4'h7); expect_out("e2.d7", 16'h1476, 1'b0, 3'd2, 1'b0);
        press(4'h8); expect_out("e2.d8", 16'h1476, 1'b0, 3'd3, 1'b0);
        press(4'h9); expect_out("e2.load", 16'h4789, 1'b1, 3'd0, 1'b0);
        tick();      expect_out("e2.after", 16'h4789, 1'b0, 3'd0, 1'b0);

        // clear and digit 5 together after one digit: digit dropped
        press(4'h3); expect_out("e3.d1", 16'h4789, 1'b0, 3'd1, 1'b0);
        digit_in = 4'h5; digit_valid = 1'b1; clear = 1'b1;
        tick();      expect_out("e3.clr_dig", 16'h4789, 1'b0, 3'd0, 1'b0);
        press(4'h1); expect_out("e3.d1b", 16'h4789, 1'b0, 3'd1, 1'b0);
        press(4'h4);
        press(4'h7); expect_out("e3.d3", 16'h4789, 1'b0, 3'd3, 1'b0);
        press(4'h6); expect_out("e3.load", 16'h1476, 1'b1, 3'd0, 1'b0);
        tick();

        // reset after two digits clears data_out and the partial entry
        press(4'h2);
        press(4'h3); expect_out("e4.d2", 16'h1476, 1'b0, 3'd2, 1'b0);
        rst = 1'b1;
        tick();      expect_out("e4.rst", 16'h0000, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        press(4'h4); expect_out("e4.d4", 16'h0000, 1'b0, 3'd1, 1'b0);
        press(4'h7);
        press(4'h8); expect_out("e4.d8", 16'h0000, 1'b0, 3'd3, 1'b0);
        press(4'h9); expect_out("e4.load", 16'h4789, 1'b1, 3'd0, 1'b0);

        // digit during LOAD is dropped
        press(4'h5); expect_out("e5.drop", 16'h4789, 1'b0, 3'd0, 1'b0);
        press(4'h1); expect_out("e5.d1", 16'h4789, 1'b0, 3'd1, 1'b0);
        press(4'h2); expect_out("e5.d2", 16'h4789, 1'b0, 3'd2, 1'b0);
        press(4'h3);
        press(4'h4); expect_out("e5.load", 16'h1234, 1'b1, 3'd0, 1'b0);

        // clear during LOAD leaves data_out alone
        pulse_clear(); expect_out("e6.clr_load", 16'h1234, 1'b0, 3'd0, 1'b0);

        // A,B then 8 idle cycles
        press(4'hA); expect_out("e7.dA", 16'h1234, 1'b0, 3'd1, 1'b0);
        press(4'hB); expect_out("e7.dB", 16'h1234, 1'b0, 3'd2, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        expect_out("e7.idle7", 16'h1234, 1'b0, 3'd2, 1'b0);
        tick();
`ifdef ENTRY_TIMEOUT_EN
        expect_out("e7.timeout", 16'h1234, 1'b0, 3'd0, 1'b1);
        tick();
        expect_out("e7.after", 16'h1234, 1'b0, 3'd0, 1'b0);
        press(4'hC); expect_out("e7.dC", 16'h1234, 1'b0, 3'd1, 1'b0);
        press(4'hD); expect_out("e7.dD", 16'h1234, 1'b0, 3'd2, 1'b0);
`else
        expect_out("e7.idle8", 16'h1234, 1'b0, 3'd2, 1'b0);
        press(4'hC); expect_out("e7.dC", 16'h1234, 1'b0, 3'd3, 1'b0);
        press(4'hD); expect_out("e7.load", 16'hABCD, 1'b1, 3'd0, 1'b0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
